// File: rtl/freeze_pkg.sv
// Shared types and constants for the freeze sequencer: state encoding, default channel
// positions and the event-counter width.
package freeze_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } freeze_state_t;

    localparam int FRZ_CH_PC  = 0;
    localparam int FRZ_CH_REG = 1;
    localparam int FRZ_CH_MEM = 2;
    localparam int FRZ_CNT_W  = 8;

    function automatic logic [FRZ_CNT_W-1:0] sat_inc(input logic [FRZ_CNT_W-1:0] v);
        return (v == '1) ? v : v + FRZ_CNT_W'(1);
    endfunction

endpackage

// File: rtl/freeze_timer.sv
// Loadable elapsed-cycle counter: reads 1 in the cycle after load, saturates, and flags done
// once the count reaches target. Registered count, combinational done; no backpressure.
module freeze_timer
    import freeze_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [FRZ_CNT_W-1:0] target,
    output logic                 done
);

    logic [FRZ_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= FRZ_CNT_W'(1);
        end else if (count != '1) begin
            count <= count + FRZ_CNT_W'(1);
        end
    end

    assign done = (count >= target);

endmodule

// File: rtl/freeze_sequencer.sv
// Freeze controller gating architectural write enables: IDLE -> DRAIN -> HOLD -> RELEASE.
// Gating is zero-latency from the registered state; no backpressure, requests are levels/sticky.
module freeze_sequencer
    import freeze_pkg::*;
#(
    parameter int                NUM_CH       = 3,
    parameter logic [NUM_CH-1:0] EARLY_MASK   = NUM_CH'(1),
    parameter int                DRAIN_CYCLES = 2,
    parameter int                MIN_HOLD     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze_req,
    input  logic                 release_req,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [NUM_CH-1:0]    we_in,
    output logic [NUM_CH-1:0]    we_out,
    output logic                 frozen,
    output logic                 freeze_ack,
    output logic                 busy,
    output logic [FRZ_CNT_W-1:0] freeze_count
);

    localparam logic [FRZ_CNT_W-1:0] DRAIN_T  = FRZ_CNT_W'(DRAIN_CYCLES);
    localparam logic [FRZ_CNT_W-1:0] HOLD_T   = FRZ_CNT_W'(MIN_HOLD);
    localparam freeze_state_t        ENTRY_ST = (DRAIN_CYCLES == 0) ? HOLD : DRAIN;

    freeze_state_t        state, state_nxt;
    logic                 release_pending;
    logic                 count_inc;
    logic                 timer_load;
    logic                 timer_done;
    logic [FRZ_CNT_W-1:0] timer_target;
    logic [NUM_CH-1:0]    gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            release_pending <= 1'b0;
            freeze_ack      <= 1'b0;
            freeze_count    <= '0;
        end else begin
            state      <= state_nxt;
            freeze_ack <= (state_nxt == HOLD) && (state != HOLD);
            if (state_nxt == RELEASE) begin
                release_pending <= 1'b0;
            end else if (release_req && (state == DRAIN || state == HOLD)) begin
                release_pending <= 1'b1;
            end
            if (count_inc) begin
                freeze_count <= sat_inc(freeze_count);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                if (freeze_req) begin
                    state_nxt = ENTRY_ST;
                    count_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (timer_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (timer_done && (release_pending || release_req)) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (freeze_req) begin
                    state_nxt = ENTRY_ST;
                    count_inc = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One timer serves both DRAIN and HOLD; reloading on every state change restarts it at 1.
    assign timer_load   = (state_nxt != state);
    assign timer_target = (state == HOLD) ? HOLD_T : DRAIN_T;

    freeze_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .target (timer_target),
        .done   (timer_done)
    );

    always_comb begin
        gate = '0;
        case (state)
            IDLE:          gate = '0;
            DRAIN:         gate = EARLY_MASK;
            HOLD, RELEASE: gate = EARLY_MASK | ch_mask;
            default:       gate = '0;
        endcase
    end

    assign we_out = we_in & ~gate;
    assign frozen = (state == HOLD);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_freeze_sequencer.sv
// Scoreboard bench for freeze_sequencer: per-cycle stimulus and expected outputs are queued
// together and compared half a cycle after each active edge.
module tb_freeze_sequencer;

    typedef struct packed {
        logic       rst;
        logic       fr;
        logic       rl;
        logic [2:0] msk;
    } stim_t;

    typedef struct packed {
        logic [2:0] we;
        logic       frz;
        logic       ack;
        logic       bsy;
        logic [7:0] cnt;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       freeze_req;
    logic       release_req;
    logic [2:0] ch_mask;
    logic [2:0] we_in;

    logic [2:0] we_out, we_out0;
    logic       frozen, frozen0, freeze_ack, freeze_ack0, busy, busy0;
    logic [7:0] freeze_count, freeze_count0;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    vectors;
    int    miscompares;

    freeze_sequencer dut (
        .clk(clk), .rst(rst), .freeze_req(freeze_req), .release_req(release_req),
        .ch_mask(ch_mask), .we_in(we_in), .we_out(we_out), .frozen(frozen),
        .freeze_ack(freeze_ack), .busy(busy), .freeze_count(freeze_count)
    );

    freeze_sequencer #(.DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .freeze_req(freeze_req), .release_req(release_req),
        .ch_mask(ch_mask), .we_in(we_in), .we_out(we_out0), .frozen(frozen0),
        .freeze_ack(freeze_ack0), .busy(busy0), .freeze_count(freeze_count0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t obs_main();
        return {we_out, frozen, freeze_ack, busy, freeze_count};
    endfunction

    function automatic obs_t obs_zero();
        return {we_out0, frozen0, freeze_ack0, busy0, freeze_count0};
    endfunction

    task automatic sched(input bit r, input bit f, input bit l, input logic [2:0] m,
                         input logic [2:0] we, input bit frz, input bit ack, input bit bsy,
                         input int cnt);
        stim_q.push_back({r, f, l, m});
        exp_q.push_back({we, frz, ack, bsy, 8'(cnt)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; freeze_req = 1'b0; release_req = 1'b0; ch_mask = 3'b111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s; obs_t e, got, got0; int k = 0;
        do_reset();
        sched(0, 0, 0, 7, 7, 0, 0, 0, 0);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); got0 = obs_zero(); vectors += 2;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            if (got0 !== e) begin
                miscompares++;
                $display("FAIL reset_drain0 step %0d: we/frz/ack/busy/cnt got %b need %b", k, got0, e);
            end
            k++;
        end
    endtask

    task automatic test_basic();
        stim_t s; obs_t e, got; int k = 0;
        sched(0, 1, 0, 7, 7, 0, 0, 0, 0);
        sched(0, 0, 0, 7, 6, 0, 0, 1, 1);
        sched(0, 0, 0, 7, 6, 0, 0, 1, 1);
        sched(0, 0, 1, 7, 0, 1, 1, 1, 1);
        repeat (3) sched(0, 0, 0, 7, 0, 1, 0, 1, 1);
        sched(0, 0, 0, 7, 0, 0, 0, 1, 1);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL basic step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_hold_off();
        stim_t s; obs_t e, got; int k = 0;
        sched(0, 1, 0, 7, 7, 0, 0, 0, 1);
        repeat (2) sched(0, 0, 0, 7, 6, 0, 0, 1, 2);
        sched(0, 0, 0, 7, 0, 1, 1, 1, 2);
        for (int i = 0; i < 59; i++) sched(0, 0, 0, 7, 0, 1, 0, 1, 2);
        sched(0, 0, 1, 7, 0, 1, 0, 1, 2);
        sched(0, 0, 0, 7, 0, 0, 0, 1, 2);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 2);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL hold_off step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_refreeze();
        stim_t s; obs_t e, got; int k = 0;
        sched(0, 1, 0, 7, 7, 0, 0, 0, 2);
        repeat (2) sched(0, 1, 0, 7, 6, 0, 0, 1, 3);
        sched(0, 1, 1, 7, 0, 1, 1, 1, 3);
        repeat (3) sched(0, 1, 0, 7, 0, 1, 0, 1, 3);
        sched(0, 1, 0, 7, 0, 0, 0, 1, 3);
        repeat (2) sched(0, 0, 0, 7, 6, 0, 0, 1, 4);
        sched(0, 0, 1, 7, 0, 1, 1, 1, 4);
        repeat (3) sched(0, 0, 0, 7, 0, 1, 0, 1, 4);
        sched(0, 0, 0, 7, 0, 0, 0, 1, 4);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 4);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL refreeze step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_drain_zero();
        stim_t s; obs_t e, got; int k = 0;
        do_reset();
        sched(0, 1, 0, 7, 7, 0, 0, 0, 0);
        sched(0, 0, 0, 7, 0, 1, 1, 1, 1);
        repeat (2) sched(0, 0, 0, 7, 0, 1, 0, 1, 1);
        sched(0, 0, 1, 7, 0, 1, 0, 1, 1);
        sched(0, 0, 0, 7, 0, 0, 0, 1, 1);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_zero(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL drain0 step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_mask();
        stim_t s; obs_t e, got; int k = 0;
        do_reset();
        sched(0, 1, 0, 7, 7, 0, 0, 0, 0);
        repeat (2) sched(0, 0, 0, 7, 6, 0, 0, 1, 1);
        sched(0, 0, 0, 4, 2, 1, 1, 1, 1);
        sched(0, 0, 0, 3, 4, 1, 0, 1, 1);
        sched(0, 0, 1, 0, 6, 1, 0, 1, 1);
        sched(0, 0, 0, 0, 6, 1, 0, 1, 1);
        sched(0, 0, 0, 0, 6, 0, 0, 1, 1);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL mask step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s; obs_t e, got; int k = 0;
        sched(0, 1, 0, 7, 7, 0, 0, 0, 1);
        repeat (2) sched(0, 0, 0, 7, 6, 0, 0, 1, 2);
        sched(0, 0, 0, 7, 0, 1, 1, 1, 2);
        sched(1, 0, 0, 7, 0, 1, 0, 1, 2);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 0);
        sched(0, 0, 0, 7, 7, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            rst = s.rst; freeze_req = s.fr; release_req = s.rl; ch_mask = s.msk;
            #1;
            got = obs_main(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid step %0d: we/frz/ack/busy/cnt got %b need %b", k, got, e);
            end
            k++;
        end
    endtask

    task automatic test_saturation();
        int acks = 0;
        int waited = 0;
        do_reset();
        @(negedge clk);
        freeze_req = 1'b1; release_req = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            #1;
            if (freeze_ack) acks++;
        end
        freeze_req = 1'b0; release_req = 1'b0;
        while (busy && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_idle_timeout: busy got %b need 0 within 20 cycles", busy);
        end
        vectors++;
        if (acks != 300) begin
            miscompares++;
            $display("FAIL sat_ack_count: got %0d need 300", acks);
        end
        vectors++;
        if (freeze_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_count: got %0d need 255", freeze_count);
        end
        vectors++;
        if (we_out !== 3'b111) begin
            miscompares++;
            $display("FAIL sat_we_out: got %b need 111", we_out);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; freeze_req = 1'b0; release_req = 1'b0;
        ch_mask = 3'b111; we_in = 3'b111;
        test_reset();
        test_basic();
        test_hold_off();
        test_refreeze();
        test_drain_zero();
        test_mask();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
